// File: rtl/reaction_timer_bcd.sv
// reaction_timer_bcd: random-foreperiod reaction timer counting ms in BCD, shown on a scanned N-digit display.
// Optional best-time register enabled by defining REACTION_BEST_TIME_EN.
module reaction_timer_bcd #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int DIGITS       = 4,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int SCAN_DIV     = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_trigger,
  input  logic              user_trigger,
  input  logic              show_best,
  output logic [3:0]        digit_val,
  output logic [DIGITS-1:0] digit_sel,
  output logic              go_lamp,
  output logic              false_start,
  output logic              overflow,
  output logic              result_valid
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = $clog2(CLKS_PER_MS + 1);
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS) + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] NINES     = {DIGITS{4'h9}};
  localparam logic [CW-1:0] DASHES    = {DIGITS{4'hF}};
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;
  localparam logic [15:0]   LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_REACT = 3'd2,
    S_SHOW  = 3'd3,
    S_FAULT = 3'd4
  } t_state;

  t_state              r_state, w_state_next;
  logic [PW-1:0]       r_presc, w_presc_next;
  logic [DW-1:0]       r_delay, w_delay_next;
  logic [CW-1:0]       r_count, w_count_next;
  logic [CW-1:0]       r_result, w_result_next;
  logic                r_overflow, w_overflow_next;
  logic [15:0]         r_lfsr;
  logic                r_start_q, r_user_q;
  logic                w_start_edge, w_user_edge, w_tick;
  logic [SW-1:0]       r_slot;
  logic [IW-1:0]       r_idx, w_idx_next;
  logic                w_slot_wrap;
  logic [DIGITS-1:0]   r_digit_sel;
  logic [3:0]          r_digit_val;
  logic                r_go, r_fault, r_valid;
  logic [CW-1:0]       w_src, w_show_src;

  // Ripple a +1 through the packed BCD digits, each wrapping 9 -> 0.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && (v[i*4 +: 4] == 4'd9)) begin
        r[i*4 +: 4] = 4'd0;
      end else if (carry) begin
        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  assign w_start_edge = start_trigger & ~r_start_q;
  assign w_user_edge  = user_trigger & ~r_user_q;
  assign w_tick       = (r_presc == PW'(CLKS_PER_MS - 1));
  assign w_slot_wrap  = (r_slot == SW'(SCAN_DIV - 1));

  // Free-running Galois LFSR and trigger edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= LFSR_SEED;
      r_start_q <= 1'b0;
      r_user_q  <= 1'b0;
    end else begin
      r_lfsr    <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
      r_start_q <= start_trigger;
      r_user_q  <= user_trigger;
    end
  end

  // Next-state and datapath updates of the measurement FSM.
  always_comb begin
    w_state_next    = r_state;
    w_presc_next    = r_presc;
    w_delay_next    = r_delay;
    w_count_next    = r_count;
    w_result_next   = r_result;
    w_overflow_next = r_overflow;
    case (r_state)
      S_IDLE, S_SHOW, S_FAULT: begin
        if (w_start_edge) begin
          w_state_next    = S_WAIT;
          w_presc_next    = {PW{1'b0}};
          w_delay_next    = DW'(MIN_DELAY_MS) + DW'(r_lfsr[RAND_BITS-1:0]);
          w_count_next    = {CW{1'b0}};
          w_overflow_next = 1'b0;
        end else begin
          w_state_next = r_state;
        end
      end
      S_WAIT: begin
        // A premature press wins over a foreperiod that expires in the same cycle.
        if (w_user_edge) begin
          w_state_next = S_FAULT;
        end else if (w_tick) begin
          w_presc_next = {PW{1'b0}};
          if (r_delay <= DW'(1)) begin
            w_delay_next = {DW{1'b0}};
            w_state_next = S_REACT;
          end else begin
            w_delay_next = r_delay - DW'(1);
          end
        end else begin
          w_presc_next = r_presc + PW'(1);
        end
      end
      S_REACT: begin
        if (w_user_edge) begin
          w_state_next  = S_SHOW;
          w_result_next = r_count;
        end else if (w_tick) begin
          w_presc_next = {PW{1'b0}};
          if (r_count == NINES) begin
            w_overflow_next = 1'b1;
            w_result_next   = NINES;
            w_state_next    = S_SHOW;
          end else begin
            w_count_next = bcd_inc(r_count);
          end
        end else begin
          w_presc_next = r_presc + PW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM state, counters and the flag outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_presc    <= {PW{1'b0}};
      r_delay    <= {DW{1'b0}};
      r_count    <= {CW{1'b0}};
      r_result   <= {CW{1'b0}};
      r_overflow <= 1'b0;
      r_go       <= 1'b0;
      r_fault    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_presc    <= w_presc_next;
      r_delay    <= w_delay_next;
      r_count    <= w_count_next;
      r_result   <= w_result_next;
      r_overflow <= w_overflow_next;
      r_go       <= (w_state_next == S_REACT);
      r_fault    <= (w_state_next == S_FAULT);
      r_valid    <= (w_state_next == S_SHOW);
    end
  end

`ifdef REACTION_BEST_TIME_EN
  logic [CW-1:0] r_best;

  // BCD order matches binary order, so a plain compare finds the faster time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best <= NINES;
    end else if ((w_state_next == S_SHOW) && (r_state != S_SHOW) &&
                 !w_overflow_next && (w_result_next < r_best)) begin
      r_best <= w_result_next;
    end
  end

  assign w_show_src = show_best ? r_best : r_result;
`else
  logic w_unused_show_best;
  assign w_unused_show_best = show_best;
  assign w_show_src         = r_result;
`endif

  // Display source selection and next scanned digit index.
  always_comb begin
    w_src = {CW{1'b0}};
    case (r_state)
      S_REACT:        w_src = r_count;
      S_FAULT:        w_src = DASHES;
      S_IDLE, S_SHOW: w_src = w_show_src;
      default:        w_src = {CW{1'b0}};
    endcase
    if (w_slot_wrap) begin
      if (r_idx == IW'(DIGITS - 1)) begin
        w_idx_next = {IW{1'b0}};
      end else begin
        w_idx_next = r_idx + IW'(1);
      end
    end else begin
      w_idx_next = r_idx;
    end
  end

  // Digit scanner: digit_val is loaded for the same slot digit_sel moves to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot      <= {SW{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_digit_sel <= {{(DIGITS-1){1'b0}}, 1'b1};
      r_digit_val <= 4'h0;
    end else begin
      r_slot      <= w_slot_wrap ? {SW{1'b0}} : r_slot + SW'(1);
      r_idx       <= w_idx_next;
      r_digit_sel <= w_slot_wrap ? {r_digit_sel[DIGITS-2:0], r_digit_sel[DIGITS-1]} : r_digit_sel;
      r_digit_val <= w_src[{w_idx_next, 2'b00} +: 4];
    end
  end

  assign digit_val    = r_digit_val;
  assign digit_sel    = r_digit_sel;
  assign go_lamp      = r_go;
  assign false_start  = r_fault;
  assign overflow     = r_overflow;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Directed self-checking bench for reaction_timer_bcd with a small-scale parameter set.
module tb_reaction_timer_bcd;
  localparam int CPM = 4;
  localparam int DG  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_trigger = 1'b0;
  logic          user_trigger = 1'b0;
  logic          show_best = 1'b0;
  logic [3:0]    digit_val;
  logic [DG-1:0] digit_sel;
  logic          go_lamp, false_start, overflow, result_valid;
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   m_lfsr;

  reaction_timer_bcd #(
    .CLKS_PER_MS(CPM), .DIGITS(DG), .MIN_DELAY_MS(2), .RAND_BITS(2), .SCAN_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .start_trigger(start_trigger), .user_trigger(user_trigger),
    .show_best(show_best), .digit_val(digit_val), .digit_sel(digit_sel), .go_lamp(go_lamp),
    .false_start(false_start), .overflow(overflow), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1 Galois form, seeded on reset.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic pulse_start(output logic [15:0] lf);
    @(negedge clk); start_trigger = 1'b1; lf = m_lfsr;
    @(negedge clk); start_trigger = 1'b0;
  endtask

  task automatic pulse_user();
    @(negedge clk); user_trigger = 1'b1;
    @(negedge clk); user_trigger = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (go_lamp !== 1'b1 && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic scan_capture(output logic [11:0] shown, output logic bad);
    logic [2:0] seen;
    shown = 12'h000; seen = 3'b000; bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      case (digit_sel)
        3'b001:  begin shown[3:0]  = digit_val; seen[0] = 1'b1; end
        3'b010:  begin shown[7:4]  = digit_val; seen[1] = 1'b1; end
        3'b100:  begin shown[11:8] = digit_val; seen[2] = 1'b1; end
        default: bad = 1'b1;
      endcase
    end
    if (seen != 3'b111) bad = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_sel [0:6];
    exp_sel = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({go_lamp, false_start, overflow, result_valid, digit_val, digit_sel} !== {4'b0000, 4'h0, 3'b001}) begin
      errors++;
      $display("FAIL reset_outputs: got go=%b fs=%b ov=%b rv=%b val=%h sel=%b expected 0 0 0 0 0 001",
               go_lamp, false_start, overflow, result_valid, digit_val, digit_sel);
    end
    rst = 1'b0;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (digit_sel !== exp_sel[k]) begin
        errors++; $display("FAIL scan_rotate[%0d]: got %b expected %b", k, digit_sel, exp_sel[k]);
      end
    end
  endtask

  // Leaves the bench at the first cycle of REACT.
  task automatic test_foreperiod();
    logic [15:0] lf;
    int          d;
    pulse_start(lf);
    d = 2 + int'(lf[1:0]);
    checks++;
    if (go_lamp !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL wait_entry: got go=%b rv=%b expected 0 0", go_lamp, result_valid);
    end
    repeat (4*d - 1) @(negedge clk);
    checks++;
    if (go_lamp !== 1'b0) begin
      errors++; $display("FAIL go_early: got %b expected 0 (delay %0d ms)", go_lamp, d);
    end
    @(negedge clk);
    checks++;
    if (go_lamp !== 1'b1) begin
      errors++; $display("FAIL go_rise: got %b expected 1 (delay %0d ms)", go_lamp, d);
    end
  endtask

  task automatic test_react_37();
    logic [11:0] shown;
    logic        bad;
    repeat (4*37 - 1) @(negedge clk);
    checks++;
    if (go_lamp !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL react_live: got go=%b rv=%b expected 1 0", go_lamp, result_valid);
    end
    pulse_user();
    checks++;
    if ({result_valid, go_lamp, overflow} !== 3'b100) begin
      errors++; $display("FAIL show_entry: got rv/go/ov=%b expected 100", {result_valid, go_lamp, overflow});
    end
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'h037) begin
      errors++; $display("FAIL result_037: got %h bad=%b expected 037", shown, bad);
    end
  endtask

  // Leaves the bench at the first cycle of REACT.
  task automatic test_false_start();
    logic [15:0] lf;
    logic [11:0] shown;
    logic        bad;
    int          n;
    pulse_start(lf);
    pulse_user();
    checks++;
    if ({false_start, go_lamp, result_valid} !== 3'b100) begin
      errors++; $display("FAIL fault_entry: got fs/go/rv=%b expected 100", {false_start, go_lamp, result_valid});
    end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (go_lamp !== 1'b0 || false_start !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL fault_hold: got go=%b fs=%b expected 0 1", go_lamp, false_start);
    end
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'hFFF) begin
      errors++; $display("FAIL fault_dashes: got %h bad=%b expected fff", shown, bad);
    end
    pulse_start(lf);
    checks++;
    if (false_start !== 1'b0 || go_lamp !== 1'b0) begin
      errors++; $display("FAIL fault_clear: got fs=%b go=%b expected 0 0", false_start, go_lamp);
    end
    wait_go(n);
    checks++;
    if (n >= 300) begin
      errors++; $display("FAIL go_timeout_fs: got %0d cycles expected under 300", n);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] shown;
    logic        bad;
    int          n;
    n = 0;
    while (result_valid !== 1'b1 && n < 4200) begin @(negedge clk); n++; end
    checks++;
    if (n != 4000) begin
      errors++; $display("FAIL overflow_time: got %0d cycles expected 4000", n);
    end
    checks++;
    if ({overflow, result_valid, go_lamp} !== 3'b110) begin
      errors++; $display("FAIL overflow_flags: got ov/rv/go=%b expected 110", {overflow, result_valid, go_lamp});
    end
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'h999) begin
      errors++; $display("FAIL overflow_999: got %h bad=%b expected 999", shown, bad);
    end
  endtask

  // Leaves the bench in REACT.
  task automatic test_back_to_back();
    logic [15:0] lf;
    logic        bad;
    int          n;
    pulse_start(lf);
    checks++;
    if ({overflow, result_valid, go_lamp} !== 3'b000) begin
      errors++; $display("FAIL restart_clear: got ov/rv/go=%b expected 000", {overflow, result_valid, go_lamp});
    end
    wait_go(n);
    checks++;
    if (n >= 300) begin
      errors++; $display("FAIL go_timeout_b2b: got %0d cycles expected under 300", n);
    end
    pulse_start(lf);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (go_lamp !== 1'b1 || result_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL start_ignored: got go=%b rv=%b expected 1 0", go_lamp, result_valid);
    end
  endtask

  task automatic test_reset_mid_react();
    logic [11:0] shown;
    logic        bad;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({go_lamp, false_start, overflow, result_valid, digit_val, digit_sel} !== {4'b0000, 4'h0, 3'b001}) begin
      errors++;
      $display("FAIL mid_reset: got go=%b fs=%b ov=%b rv=%b val=%h sel=%b expected 0 0 0 0 0 001",
               go_lamp, false_start, overflow, result_valid, digit_val, digit_sel);
    end
    rst = 1'b0;
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'h000 || go_lamp !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got %h go=%b bad=%b expected 000 0", shown, go_lamp, bad);
    end
  endtask

`ifdef REACTION_BEST_TIME_EN
  task automatic run_reaction(input int ticks, output logic ok);
    logic [15:0] lf;
    int          n;
    pulse_start(lf);
    wait_go(n);
    repeat (4*ticks - 1) @(negedge clk);
    pulse_user();
    ok = (n < 300) && (result_valid === 1'b1);
  endtask

  task automatic test_best();
    logic [11:0] shown;
    logic        bad, ok1, ok2, ok3;
    show_best = 1'b1;
    repeat (2) @(negedge clk);
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'h999) begin
      errors++; $display("FAIL best_reset: got %h bad=%b expected 999", shown, bad);
    end
    show_best = 1'b0;
    run_reaction(120, ok1);
    run_reaction(85, ok2);
    run_reaction(200, ok3);
    checks++;
    if (!(ok1 && ok2 && ok3)) begin
      errors++; $display("FAIL best_runs: got ok=%b%b%b expected 111", ok1, ok2, ok3);
    end
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'h200) begin
      errors++; $display("FAIL best_last: got %h bad=%b expected 200", shown, bad);
    end
    show_best = 1'b1;
    repeat (2) @(negedge clk);
    scan_capture(shown, bad);
    checks++;
    if (bad || shown !== 12'h085) begin
      errors++; $display("FAIL best_085: got %h bad=%b expected 085", shown, bad);
    end
    show_best = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_foreperiod();
    test_react_37();
    test_false_start();
    test_overflow();
    test_back_to_back();
    test_reset_mid_react();
`ifdef REACTION_BEST_TIME_EN
    test_best();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
